alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  EX-stage execution unit; consumer of the 4-bit ALUCtrl code produced by ALU control.
//  Single-cycle ops return a registered result one cycle after issue.
//  MUL (code 5) runs on an iterative shift-add multiplier and holds ready_o low while busy,
//  so the hazard unit can stall IF/ID/EX.
//  Zero_o drives beq resolution.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width; shift amount = data2_i[$clog2(DATA_WIDTH)-1:0]
//  MUL_BITS_PER_CYCLE 1  multiplier bits retired per cycle; legal 1,2,4; must divide DATA_WIDTH
// PORTS
//  clk_i      in   1   clock, rising edge
//  rst_i      in   1   synchronous reset, active-high
//  flush_i    in   1   synchronous abort of any in-flight op (branch mispredict)
//  valid_i    in   1   operation issue; accepted only when valid_i & ready_o at clk edge
//  ALUCtrl_i  in   4   op code: 0 and,1 xor,2 sll,3 add,4 sub,5 mul,6 addi,7 srai,8 ld/sd addr,9 beq
//  data1_i    in   DW  rs1 operand
//  data2_i    in   DW  rs2 operand or sign-extended immediate
//  ready_o    out  1   unit can accept an op this cycle
//  valid_o    out  1   one-cycle pulse: data_o/Zero_o hold a new result
//  data_o     out  DW  result, held until next valid_o
//  Zero_o     out  1   (data_o == 0), registered with data_o
// BEHAVIOUR
//  Reset: state=IDLE, ready_o=1, valid_o=0, data_o=0, Zero_o=1 (consistent with data_o=0).
//  Reset mid-MUL: partial product discarded, no valid_o.
//  Op semantics (all mod 2^DW):
//   - 0 d1&d2; 1 d1^d2; 2 d1<<d2[4:0]; 3/6/8 d1+d2; 4/9 d1-d2
//   - 7 $signed(d1)>>>d2[4:0]; 5 low DW bits of d1*d2 (sign-agnostic)
//   - codes 10-15: result 0, still completes as a single-cycle op.
//  Single-cycle ops: accepted at edge T -> valid_o=1 in cycle T+1. ready_o stays 1, so back-to-back issue every cycle.
//  MUL latency: N = DW/MUL_BITS_PER_CYCLE.
//   - Accept at T -> ready_o=0 from T+1.
//   - Completion: valid_o=1 and ready_o=1 in cycle T+N+1. A new op may issue on that same edge.
//  FSM:
//   - IDLE --valid_i&ready_o&code==5--> MUL
//   - MUL --count==N-1--> DONE
//   - DONE --> IDLE (or MUL if a new mul issues in DONE)
//   - Counter counts 0..N-1.
//   - Operands latched at accept; later input changes are ignored.
//  valid_i while ready_o=0: ignored, not queued; the issuer must hold it.
//  flush_i: highest priority after rst_i.
//   - Returns the FSM to IDLE and suppresses valid_o for the flushed op.
//   - ready_o=1 next cycle.
//   - data_o/Zero_o keep their previous value.
//   - flush_i & valid_i on the same edge: the op is dropped.
//  No output is combinational from inputs; all outputs are registered.
// STRUCTURE
//  alu_pkg:
//   - localparams ALU_AND..ALU_BEQ (0..9), shared with ALU control.
//   - FSM state encoding IDLE/MUL/DONE.
//  Sub-module mul_iter (start, operands, done, product; radix per MUL_BITS_PER_CYCLE).
//  The remaining single-cycle datapath and FSM live in alu_exec_unit.
// TESTING
//  1. Reset then idle -> ready_o=1, valid_o=0, data_o=0, Zero_o=1.
//  2. Back-to-back issue of add 5+7, sub 5-5, xor 0xF0^0xFF on three consecutive edges
//     -> valid_o three consecutive cycles; data 12, 0 (Zero_o=1), 0x0F.
//  3. srai 0x80000000,4 -> 0xF8000000; sll 1,31 -> 0x80000000; code 12 -> 0 with valid_o.
//  4. mul 0xFFFFFFFF*3 (DW=32, BPC=1) at T -> ready_o=0 T+1..T+32; valid_o only at T+33 with 0xFFFFFFFD.
//     valid_i held during busy is not accepted.
//  5. mul 6*7 issued; flush_i at T+10 -> no valid_o, ready_o=1 at T+11, data_o unchanged.
//     Repeat the test with rst_i in place of flush_i -> outputs return to reset values.
//  6. Mul completes at T+33 with a new add 2+2 issued on that edge
//     -> valid_o at T+33 (mul result) and T+34 (4).
//  7. Randomized mix vs reference model for BPC=1,2,4.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and execution-unit FSM encoding
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_XOR  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_MUL  = 4'd5;
  localparam logic [3:0] ALU_ADDI = 4'd6;
  localparam logic [3:0] ALU_SRAI = 4'd7;
  localparam logic [3:0] ALU_LDSD = 4'd8;
  localparam logic [3:0] ALU_BEQ  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per step
module mul_iter #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int STEPS = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] partial;
  logic [CW-1:0]         count;
  logic                  busy;

  // product is the accumulator including the current step, so the final
  // value is visible on the same cycle done is high
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
    product = acc + partial;
    done    = busy && (count == CW'(STEPS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
      count  <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage execution unit: registered single-cycle ALU plus iterative MUL
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [3:0]            ALUCtrl_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  Zero_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  is_mul;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [SHW-1:0]        shamt;
  logic                  valid_next;
  logic [DATA_WIDTH-1:0] data_next;

  assign ready_o = (state != ST_MUL);
  assign accept  = valid_i & ready_o & ~flush_i;
  assign is_mul  = (ALUCtrl_i == ALU_MUL);
  assign shamt   = data2_i[SHW-1:0];

  always_comb begin
    alu_result = '0;
    case (ALUCtrl_i)
      ALU_AND:                      alu_result = data1_i & data2_i;
      ALU_XOR:                      alu_result = data1_i ^ data2_i;
      ALU_SLL:                      alu_result = data1_i << shamt;
      ALU_ADD, ALU_ADDI, ALU_LDSD:  alu_result = data1_i + data2_i;
      ALU_SUB, ALU_BEQ:             alu_result = data1_i - data2_i;
      ALU_SRAI:                     alu_result = $unsigned($signed(data1_i) >>> shamt);
      default:                      alu_result = '0;
    endcase
  end

  // Operands are captured inside the multiplier at accept, so later input
  // changes during the busy window have no effect.
  mul_iter #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk    (clk_i),
    .rst    (rst_i),
    .abort  (flush_i),
    .start  (accept & is_mul),
    .a      (data1_i),
    .b      (data2_i),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: state_next = (accept && is_mul) ? ST_MUL : ST_IDLE;
        ST_MUL:           state_next = mul_done ? ST_DONE : ST_MUL;
        default:          state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    valid_next = 1'b0;
    data_next  = data_o;
    if (!flush_i) begin
      if (state == ST_MUL) begin
        if (mul_done) begin
          valid_next = 1'b1;
          data_next  = mul_product;
        end
      end else if (accept && !is_mul) begin
        valid_next = 1'b1;
        data_next  = alu_result;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      Zero_o  <= 1'b1;
    end else begin
      valid_o <= valid_next;
      data_o  <= data_next;
      Zero_o  <= (data_next == '0);
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed and randomized checks of alu_exec_unit at BPC 1, 2 and 4
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst, flush, valid;
  logic [3:0]  ctrl;
  logic [31:0] d1, d2;

  logic        rdy1, vld1, z1;
  logic [31:0] dat1;
  logic        rdy2, vld2, z2;
  logic [31:0] dat2;
  logic        rdy4, vld4, z4;
  logic [31:0] dat4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_WIDTH(32), .MUL_BITS_PER_CYCLE(1)) u_bpc1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ALUCtrl_i(ctrl),
    .data1_i(d1), .data2_i(d2), .ready_o(rdy1), .valid_o(vld1), .data_o(dat1), .Zero_o(z1));
  alu_exec_unit #(.DATA_WIDTH(32), .MUL_BITS_PER_CYCLE(2)) u_bpc2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ALUCtrl_i(ctrl),
    .data1_i(d1), .data2_i(d2), .ready_o(rdy2), .valid_o(vld2), .data_o(dat2), .Zero_o(z2));
  alu_exec_unit #(.DATA_WIDTH(32), .MUL_BITS_PER_CYCLE(4)) u_bpc4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ALUCtrl_i(ctrl),
    .data1_i(d1), .data2_i(d2), .ready_o(rdy4), .valid_o(vld4), .data_o(dat4), .Zero_o(z4));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ctrl  = op;
    d1    = a;
    d2    = b;
    valid = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ready"}, 32'(rdy1), 32'd1);
    check({tag, " valid"}, 32'(vld1), 32'd0);
    check({tag, " data"},  dat1,      32'd0);
    check({tag, " zero"},  32'(z1),   32'd1);
  endtask

  initial begin
    int          busy_bad;
    int          late_valid;
    int          lat[3];
    logic [31:0] got[3];
    logic [31:0] ra, rb, prod;

    vecs[0]  = '{4'd3,  32'd5,        32'd7,        32'd12};
    vecs[1]  = '{4'd4,  32'd5,        32'd5,        32'd0};
    vecs[2]  = '{4'd1,  32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F};
    vecs[3]  = '{4'd7,  32'h8000_0000, 32'd4,        32'hF800_0000};
    vecs[4]  = '{4'd2,  32'd1,        32'd31,       32'h8000_0000};
    vecs[5]  = '{4'd12, 32'd5,        32'd3,        32'd0};
    vecs[6]  = '{4'd0,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00};
    vecs[7]  = '{4'd6,  32'hFFFF_FFFF, 32'd1,        32'd0};
    vecs[8]  = '{4'd8,  32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC};
    vecs[9]  = '{4'd9,  32'd7,        32'd9,        32'hFFFF_FFFE};
    vecs[10] = '{4'd7,  32'h7FFF_FFF0, 32'd4,        32'h07FF_FFFF};
    vecs[11] = '{4'd2,  32'd3,        32'h0000_0021, 32'd6};
    vecs[12] = '{4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0};
    vecs[13] = '{4'd4,  32'd0,        32'd1,        32'hFFFF_FFFF};

    rst = 1'b1; flush = 1'b0; valid = 1'b0; ctrl = 4'd0; d1 = '0; d2 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_reset_state("reset");

    // back-to-back single-cycle ops, one result per cycle
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      check($sformatf("vec%0d valid", i), 32'(vld1), 32'd1);
      check($sformatf("vec%0d ready", i), 32'(rdy1), 32'd1);
      check($sformatf("vec%0d data", i),  dat1,      vecs[i].exp);
      check($sformatf("vec%0d zero", i),  32'(z1),   32'(vecs[i].exp == 32'd0));
    end
    valid = 1'b0;
    tick();
    check("idle valid", 32'(vld1), 32'd0);
    check("idle hold data", dat1, 32'hFFFF_FFFF);

    // mul busy window with an add held on valid_i, accepted on the completion edge
    issue(4'd5, 32'hFFFF_FFFF, 32'd3);
    tick();
    check("mul busy ready", 32'(rdy1), 32'd0);
    issue(4'd3, 32'd2, 32'd2);
    busy_bad = 0;
    for (int k = 2; k <= 33; k++) begin
      tick();
      if (k < 33 && (vld1 || rdy1)) busy_bad++;
    end
    check("mul busy window", 32'(busy_bad), 32'd0);
    check("mul valid T+33", 32'(vld1), 32'd1);
    check("mul ready T+33", 32'(rdy1), 32'd1);
    check("mul data",       dat1,      32'hFFFF_FFFD);
    tick();
    valid = 1'b0;
    check("add after mul valid", 32'(vld1), 32'd1);
    check("add after mul data",  dat1,      32'd4);
    tick();
    check("add after mul single pulse", 32'(vld1), 32'd0);

    // flush mid-mul: no result, ready next cycle, data held
    issue(4'd5, 32'd6, 32'd7);
    tick();
    valid = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush ready", 32'(rdy1), 32'd1);
    check("flush valid", 32'(vld1), 32'd0);
    check("flush data",  dat1,      32'd4);
    check("flush zero",  32'(z1),   32'd0);
    late_valid = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (vld1) late_valid++;
    end
    check("flush no late valid", 32'(late_valid), 32'd0);

    // flush with an issue on the same edge drops the op
    issue(4'd3, 32'd1, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    check("flush+issue valid", 32'(vld1), 32'd0);
    check("flush+issue data",  dat1,      32'd4);

    // reset mid-mul
    issue(4'd5, 32'd6, 32'd7);
    tick();
    valid = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst mid-mul");
    late_valid = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (vld1) late_valid++;
    end
    check("rst no late valid", 32'(late_valid), 32'd0);

    // randomized multiplies compared against a 64-bit product model at every radix
    for (int r = 0; r < 5; r++) begin
      ra = (r == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = (r == 0) ? 32'hFFFF_FFFF : $urandom;
      prod = 32'(64'(ra) * 64'(rb));
      issue(4'd5, ra, rb);
      tick();
      valid = 1'b0;
      ctrl  = 4'd3;
      d1    = $urandom;
      d2    = $urandom;
      lat = '{0, 0, 0};
      got = '{32'd0, 32'd0, 32'd0};
      for (int c = 1; c <= 40; c++) begin
        if (vld1 && lat[0] == 0) begin lat[0] = c; got[0] = dat1; end
        if (vld2 && lat[1] == 0) begin lat[1] = c; got[1] = dat2; end
        if (vld4 && lat[2] == 0) begin lat[2] = c; got[2] = dat4; end
        tick();
      end
      check($sformatf("rnd%0d bpc1 latency", r), 32'(lat[0]), 32'd33);
      check($sformatf("rnd%0d bpc2 latency", r), 32'(lat[1]), 32'd17);
      check($sformatf("rnd%0d bpc4 latency", r), 32'(lat[2]), 32'd9);
      check($sformatf("rnd%0d bpc1 data", r), got[0], prod);
      check($sformatf("rnd%0d bpc2 data", r), got[1], prod);
      check($sformatf("rnd%0d bpc4 data", r), got[2], prod);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
